tran_byte_ser: RTL and testbench



---
 rtl/tran_byte_ser.sv | 171 +++++++++++++++++
 tb/tb_tran_byte_ser.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tran_byte_ser.sv
// Byte FIFO followed by a start/data/stop serialiser, MSB first, line idles high.
// Optional even-parity bit after the data bits when TRAN_SER_PARITY_EN is defined.
module tran_byte_ser #(
  parameter int DEPTH    = 4,
  parameter int BAUD_DIV = 4,
  parameter int CW       = 3
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          In_en,
  input  logic [7:0]    In,
  output logic          Tx,
  output logic          Busy,
  output logic          Full,
  output logic          Ovf,
  output logic [CW-1:0] Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

`ifdef TRAN_SER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state, state_n;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx_q, tx_n;
  logic          ovf;
  logic          pop, push_ok, baud_last, has_data;
`ifdef TRAN_SER_PARITY_EN
  logic          par, par_n;
`endif

  assign baud_last = (baud == BW'(BAUD_DIV - 1));
  assign has_data  = (count != '0);
  // A full FIFO still accepts a byte when the FSM frees a slot on the same edge.
  assign push_ok   = In_en && ((count != CW'(DEPTH)) || pop);

  always_comb begin
    state_n = state;
    baud_n  = baud_last ? '0 : baud + BW'(1);
    idx_n   = idx;
    shift_n = shift;
    tx_n    = tx_q;
    pop     = 1'b0;
`ifdef TRAN_SER_PARITY_EN
    par_n   = par;
`endif
    unique case (state)
      IDLE: begin
        baud_n = '0;
        if (has_data) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
`ifdef TRAN_SER_PARITY_EN
          par_n   = ^mem[rd_ptr];
`endif
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          state_n = DATA;
          idx_n   = 3'd7;
          tx_n    = shift[7];
        end
      end
      DATA: begin
        if (baud_last) begin
          if (idx == 3'd0) begin
`ifdef TRAN_SER_PARITY_EN
            state_n = PAR;
            tx_n    = par;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            shift_n = {shift[6:0], 1'b0};
            tx_n    = shift[6];
            idx_n   = idx - 3'd1;
          end
        end
      end
`ifdef TRAN_SER_PARITY_EN
      PAR: begin
        if (baud_last) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_last) begin
          if (has_data) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
`ifdef TRAN_SER_PARITY_EN
            par_n   = ^mem[rd_ptr];
`endif
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_comb begin
    count_n = count;
    if (push_ok && !pop)      count_n = count + CW'(1);
    else if (!push_ok && pop) count_n = count - CW'(1);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state  <= IDLE;
      baud   <= '0;
      idx    <= '0;
      shift  <= '0;
      tx_q   <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
`ifdef TRAN_SER_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      state <= state_n;
      baud  <= baud_n;
      idx   <= idx_n;
      shift <= shift_n;
      tx_q  <= tx_n;
      count <= count_n;
`ifdef TRAN_SER_PARITY_EN
      par   <= par_n;
`endif
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (In_en && !push_ok) ovf <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (push_ok) mem[wr_ptr] <= In;
  end

  assign Tx    = tx_q;
  assign Busy  = (state != IDLE) || has_data;
  assign Full  = (count == CW'(DEPTH));
  assign Ovf   = ovf;
  assign Count = count;

endmodule

// File: tb/tb_tran_byte_ser.sv
// Directed bench for tran_byte_ser: frames, back-to-back, overflow, full push with pop, async reset.
module tb_tran_byte_ser;

  localparam int DEPTH = 4;
  localparam int BAUD  = 4;
  localparam int CW    = 3;
`ifdef TRAN_SER_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * BAUD;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          In_en;
  logic [7:0]    In;
  logic          Tx, Busy, Full, Ovf;
  logic [CW-1:0] Count;

  int total = 0;
  int bad   = 0;

  tran_byte_ser #(.DEPTH(DEPTH), .BAUD_DIV(BAUD), .CW(CW)) dut (
    .Clk(Clk), .Rst(Rst), .In_en(In_en), .In(In),
    .Tx(Tx), .Busy(Busy), .Full(Full), .Ovf(Ovf), .Count(Count)
  );

  always #5 Clk = ~Clk;

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level expected i cycles after the edge that starts the frame.
  function automatic logic exp_bit(input logic [7:0] d, input int i);
    int b;
    b = i / BAUD;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[8-b];
`ifdef TRAN_SER_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic frame(input logic [7:0] d, input int first, input int last);
    for (int i = first; i < last; i++) begin
      chk($sformatf("tx_%02h_%0d", d, i), 32'(Tx), 32'(exp_bit(d, i)));
      if (i == first || i == F - 1) chk($sformatf("busy_%02h_%0d", d, i), 32'(Busy), 32'd1);
      step(1);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_tx"}, 32'(Tx), 32'd1);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_count"}, 32'(Count), 32'd0);
  endtask

  initial begin
    Rst = 1'b0; In_en = 1'b0; In = 8'h00;
    step(3);
    idle_chk("rst");
    chk("rst_full", 32'(Full), 32'd0);
    chk("rst_ovf", 32'(Ovf), 32'd0);
    Rst = 1'b1;
    step(2);

    // Single byte A5
    In = 8'hA5; In_en = 1'b1;
    step(1);
    In_en = 1'b0;
    chk("a5_count_push", 32'(Count), 32'd1);
    chk("a5_busy_push", 32'(Busy), 32'd1);
    chk("a5_tx_push", 32'(Tx), 32'd1);
    step(1);
    chk("a5_count_pop", 32'(Count), 32'd0);
    frame(8'hA5, 0, F);
    idle_chk("a5_end");

    // Byte 07 (odd parity data)
    In = 8'h07; In_en = 1'b1;
    step(1);
    In_en = 1'b0;
    step(1);
    frame(8'h07, 0, F);
    idle_chk("b07_end");

    // Back-to-back 3C, C3
    In = 8'h3C; In_en = 1'b1;
    step(1);
    In = 8'hC3;
    step(1);
    In_en = 1'b0;
    chk("b2b_count", 32'(Count), 32'd1);
    frame(8'h3C, 0, F);
    frame(8'hC3, 0, F);
    idle_chk("b2b_end");

    // Overflow: 01..06 on consecutive cycles
    for (int i = 1; i <= 6; i++) begin
      In = 8'(i); In_en = 1'b1;
      step(1);
      if (i == 2) begin
        chk("ovf_e2_count", 32'(Count), 32'd1);
        chk("ovf_e2_tx", 32'(Tx), 32'd0);
      end
      if (i == 5) begin
        chk("ovf_e5_count", 32'(Count), 32'd4);
        chk("ovf_e5_full", 32'(Full), 32'd1);
        chk("ovf_e5_ovf", 32'(Ovf), 32'd0);
      end
      if (i == 6) begin
        chk("ovf_e6_count", 32'(Count), 32'd4);
        chk("ovf_e6_ovf", 32'(Ovf), 32'd1);
      end
    end
    In_en = 1'b0;
    frame(8'h01, 4, F);
    frame(8'h02, 0, F);
    frame(8'h03, 0, F);
    frame(8'h04, 0, F);
    frame(8'h05, 0, F);
    idle_chk("ovf_end");
    chk("ovf_sticky", 32'(Ovf), 32'd1);
    chk("ovf_full_clr", 32'(Full), 32'd0);

    // Asynchronous reset in the middle of a data bit
    In = 8'h00; In_en = 1'b1;
    step(1);
    In = 8'h11;
    step(1);
    In = 8'h22;
    step(1);
    In_en = 1'b0;
    step(5);
    chk("mid_pre_tx", 32'(Tx), 32'd0);
    chk("mid_pre_count", 32'(Count), 32'd2);
    #2 Rst = 1'b0;
    #1;
    idle_chk("mid_rst");
    chk("mid_rst_ovf", 32'(Ovf), 32'd0);
    chk("mid_rst_full", 32'(Full), 32'd0);
    step(2);
    Rst = 1'b1;
    for (int i = 0; i < F + 5; i++) begin
      chk($sformatf("post_rst_tx_%0d", i), 32'(Tx), 32'd1);
      step(1);
    end
    idle_chk("post_rst");

    // Full FIFO plus push on the last STOP cycle
    In = 8'hAA; In_en = 1'b1;
    step(1);
    In = 8'hBB;
    step(1);
    In = 8'hCC;
    step(1);
    In = 8'hDD;
    step(1);
    In = 8'hEE;
    step(1);
    In_en = 1'b0;
    chk("fp_count4", 32'(Count), 32'd4);
    chk("fp_full", 32'(Full), 32'd1);
    frame(8'hAA, 3, F - 1);
    chk("fp_stop_last_tx", 32'(Tx), 32'd1);
    In = 8'h55; In_en = 1'b1;
    step(1);
    In_en = 1'b0;
    chk("fp_count_hold", 32'(Count), 32'd4);
    chk("fp_full_hold", 32'(Full), 32'd1);
    chk("fp_ovf_clear", 32'(Ovf), 32'd0);
    frame(8'hBB, 0, F);
    frame(8'hCC, 0, F);
    frame(8'hDD, 0, F);
    frame(8'hEE, 0, F);
    frame(8'h55, 0, F);
    idle_chk("fp_end");
    chk("fp_end_ovf", 32'(Ovf), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
